// File: rtl/spi_flash_pkg.sv
// Shared constants and state encoding for the SPI flash streamer.
//   CMD_READ / CMD_FAST_READ : flash read opcodes (0x03 / 0x0B)
//   DUMMY_CYCLES             : SCK cycles between address and data for fast read
//   ADDR_BITS                : flash byte address width
//   state_e                  : transfer sequencer states
package spi_flash_pkg;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;
    localparam int         DUMMY_CYCLES  = 8;
    localparam int         ADDR_BITS     = 24;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        DATA,
        PAUSE,
        FINISH
    } state_e;

endpackage

// File: rtl/spi_stream_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output.
//   clk, reset      : clock, synchronous active-high reset
//   i_flush         : empty the FIFO on the next edge (wins over push/pop)
//   i_push, i_din   : write a word; ignored when full
//   i_pop           : drop the head word; ignored when empty
//   o_dout          : head word, valid while o_empty = 0
//   o_empty, o_full : occupancy flags
//   o_level         : number of stored words (0..DEPTH)
module spi_stream_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_din,
    input  logic                     i_pop,
    output logic [DATA_W-1:0]        o_dout,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_q;
    logic [AW-1:0]     rd_q;
    logic [LW-1:0]     level_q;
    logic              do_push;
    logic              do_pop;

    assign o_empty = (level_q == '0);
    assign o_full  = (level_q == LW'(DEPTH));
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;
    assign o_dout  = mem_q[rd_q];
    assign o_level = level_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= i_din;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= wr_q + AW'(do_push);
            rd_q    <= rd_q + AW'(do_pop);
            level_q <= level_q + LW'(do_push) - LW'(do_pop);
        end
    end

endmodule

// File: rtl/spi_flash_streamer.sv
// Streams a region of SPI NOR flash (mode 0, read 0x03 or fast read 0x0B)
// into a FWFT FIFO. Start address and word count are given at start time;
// SCK is stretched low at word boundaries while the FIFO is full.
//   clk, reset                : clock, synchronous active-high reset
//   i_start, i_addr, i_len    : start pulse, byte address, word count
//   i_abort                   : stop transfer, release CS, flush FIFO
//   o_busy, o_done            : transfer in progress / completion pulse
//   i_fifo_rd, o_fifo_*       : FIFO read side (dout, empty, low, level)
//   SPI_CSS/CLK/MOSI/MISO     : flash bus
module spi_flash_streamer
    import spi_flash_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_W      = 16,
    parameter int CLK_DIV    = 1,
    parameter int FAST_READ  = 0,
    parameter int LOW_WATER  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_start,
    input  logic [23:0]                   i_addr,
    input  logic [LEN_W-1:0]              i_len,
    input  logic                          i_abort,
    output logic                          o_busy,
    output logic                          o_done,
    input  logic                          i_fifo_rd,
    output logic [DATA_W-1:0]             o_fifo_dout,
    output logic                          o_fifo_empty,
    output logic                          o_fifo_low,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          SPI_CSS,
    output logic                          SPI_CLK,
    output logic                          SPI_MOSI,
    input  logic                          SPI_MISO
);
    localparam int         DIV_W  = 8;
    localparam logic [7:0] OPCODE = (FAST_READ != 0) ? CMD_FAST_READ : CMD_READ;

    state_e               state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [5:0]           bit_q, bit_d;
    logic [31:0]          tx_q, tx_d;
    logic [6:0]           shift_q, shift_d;
    logic [DATA_W-1:0]    word_q, word_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic                 sck_q, sck_d;
    logic                 css_q, css_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 push_q, push_d;
    logic                 tick;
    logic                 fifo_full;
    logic [7:0]           rx_byte;

    // One tick per SCK half-period.
    assign tick    = (div_q == DIV_W'(CLK_DIV - 1));
    assign rx_byte = {shift_q, SPI_MISO};

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        shift_d = shift_q;
        word_d  = word_q;
        len_d   = len_q;
        sck_d   = sck_q;
        css_d   = css_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        push_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    if (i_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = CMD;
                        css_d   = 1'b0;
                        busy_d  = 1'b1;
                        div_d   = '0;
                        bit_d   = '0;
                        len_d   = i_len;
                        // MSB of the shifter drives MOSI, so bit 7 of the
                        // opcode is on the wire as CS falls.
                        tx_d    = {OPCODE, i_addr};
                    end
                end
            end
            PAUSE: begin
                if (!fifo_full) begin
                    state_d = DATA;
                end
            end
            FINISH: begin
                if (tick) begin
                    state_d = IDLE;
                    css_d   = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    div_d   = '0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: begin
                // Hold SCK low before the first rising edge of a word while
                // the FIFO cannot take it; the divider phase is preserved.
                if (state_q == DATA && !sck_q && bit_q == '0 && fifo_full) begin
                    state_d = PAUSE;
                end else if (!tick) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d = '0;
                    sck_d = ~sck_q;
                    if (!sck_q) begin
                        // Rising edge: sample MISO in the same cycle.
                        if (state_q == DATA) begin
                            shift_d = rx_byte[6:0];
                            // Completed bytes enter at the top and move down,
                            // leaving the first byte in bits [7:0].
                            if (bit_q[2:0] == 3'd7) begin
                                word_d = (DATA_W'(rx_byte) << (DATA_W - 8)) | (word_q >> 8);
                            end
                            if (bit_q == 6'(DATA_W - 1)) begin
                                push_d = 1'b1;
                                len_d  = len_q - LEN_W'(1);
                            end
                        end
                    end else begin
                        // Falling edge: next MOSI bit, advance bit counter.
                        tx_d  = {tx_q[30:0], 1'b0};
                        bit_d = bit_q + 6'd1;
                        if (state_q == CMD && bit_q == 6'd7) begin
                            state_d = ADDR;
                            bit_d   = '0;
                        end else if (state_q == ADDR && bit_q == 6'(ADDR_BITS - 1)) begin
                            state_d = (FAST_READ != 0) ? DUMMY : DATA;
                            bit_d   = '0;
                        end else if (state_q == DUMMY && bit_q == 6'(DUMMY_CYCLES - 1)) begin
                            state_d = DATA;
                            bit_d   = '0;
                        end else if (state_q == DATA && bit_q == 6'(DATA_W - 1)) begin
                            bit_d = '0;
                            if (len_q == '0) begin
                                state_d = FINISH;
                            end
                        end
                    end
                end
            end
        endcase

        if (i_abort) begin
            state_d = IDLE;
            css_d   = 1'b1;
            sck_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            push_d  = 1'b0;
            tx_d    = '0;
            div_d   = '0;
            bit_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            shift_q <= '0;
            word_q  <= '0;
            len_q   <= '0;
            sck_q   <= 1'b0;
            css_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            push_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            len_q   <= len_d;
            sck_q   <= sck_d;
            css_q   <= css_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            push_q  <= push_d;
        end
    end

    spi_stream_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_flush (i_abort),
        .i_push  (push_q),
        .i_din   (word_q),
        .i_pop   (i_fifo_rd),
        .o_dout  (o_fifo_dout),
        .o_empty (o_fifo_empty),
        .o_full  (fifo_full),
        .o_level (o_fifo_level)
    );

    assign o_fifo_low = (int'(o_fifo_level) < LOW_WATER);
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign SPI_CSS    = css_q;
    assign SPI_CLK    = sck_q;
    assign SPI_MOSI   = tx_q[31];

endmodule

// File: tb/tb_spi_flash_streamer.sv
// Bench for spi_flash_streamer: instance 0 is normal read (CLK_DIV=1),
// instance 1 is fast read (CLK_DIV=2); both 32-bit words, 4-deep FIFO.
// Each instance has a flash model that serves byte k = (k+1)*0x11 after
// the command header and captures the first 32 MOSI bits.
module tb_spi_flash_streamer;
    localparam int DW = 32;
    localparam int LW = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0]    start, abort, fifo_rd, busy, done, empty, low, css, sck, mosi, miso;
    logic [23:0]   addr;
    logic [LW-1:0] len;
    logic [DW-1:0] dout [2];
    logic [2:0]    level [2];

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        int          inst;
        logic [23:0] a;
        logic [15:0] l;
        logic [31:0] cmd;
        int          rises;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    vec_t tbl [4];

    function automatic logic [7:0] bval(int k);
        return 8'((k + 1) * 17);
    endfunction

    function automatic logic fbit(int d);
        logic [7:0] b;
        if (d < 0) return 1'b1;
        b = bval(d / 8);
        return b[7 - (d % 8)];
    endfunction

    function automatic logic [31:0] exp_word(int j);
        return {bval(4*j + 3), bval(4*j + 2), bval(4*j + 1), bval(4*j)};
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g
        localparam int HDR = 32 + 8 * gi;
        int          rises = 0;
        int          base = 0;
        int          falls = 0;
        logic [31:0] cap = '0;

        spi_flash_streamer #(
            .DATA_W(DW), .FIFO_DEPTH(4), .LEN_W(LW),
            .CLK_DIV(gi + 1), .FAST_READ(gi), .LOW_WATER(2)
        ) dut (
            .clk(clk), .reset(reset),
            .i_start(start[gi]), .i_addr(addr), .i_len(len), .i_abort(abort[gi]),
            .o_busy(busy[gi]), .o_done(done[gi]),
            .i_fifo_rd(fifo_rd[gi]), .o_fifo_dout(dout[gi]), .o_fifo_empty(empty[gi]),
            .o_fifo_low(low[gi]), .o_fifo_level(level[gi]),
            .SPI_CSS(css[gi]), .SPI_CLK(sck[gi]), .SPI_MOSI(mosi[gi]), .SPI_MISO(miso[gi])
        );

        always @(negedge css[gi]) begin
            base  <= rises;
            falls <= falls + 1;
        end

        always @(posedge sck[gi]) begin
            if (rises - base < 32) cap <= {cap[30:0], mosi[gi]};
            rises <= rises + 1;
        end

        assign miso[gi] = fbit(rises - base - HDR);
    end

    function automatic int xr(int i);
        return (i == 0) ? (g[0].rises - g[0].base) : (g[1].rises - g[1].base);
    endfunction
    function automatic int rraw(int i);
        return (i == 0) ? g[0].rises : g[1].rises;
    endfunction
    function automatic int nfalls(int i);
        return (i == 0) ? g[0].falls : g[1].falls;
    endfunction
    function automatic logic [31:0] mcap(int i);
        return (i == 0) ? g[0].cap : g[1].cap;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic kick(int i, logic [23:0] a, logic [LW-1:0] l);
        addr     = a;
        len      = l;
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    task automatic pop(int i);
        fifo_rd[i] = 1'b1;
        @(negedge clk);
        fifo_rd[i] = 1'b0;
    endtask

    task automatic wait_done(int i, output int dones, output logic dcss, output logic dbusy);
        int c;
        dones = 0;
        dcss  = 1'b0;
        dbusy = 1'b1;
        for (c = 0; c < 4000; c++) begin
            if (done[i]) begin
                dones++;
                dcss  = css[i];
                dbusy = busy[i];
                break;
            end
            @(negedge clk);
        end
        chk("done_timeout", 64'(c < 4000), 64'd1);
        repeat (3) begin
            @(negedge clk);
            if (done[i]) dones++;
        end
    endtask

    initial begin
        int          dones, j, r, f;
        logic        dcss, dbusy;
        logic [31:0] ew;

        tbl[0] = '{0, 24'h012345, 16'd2, 32'h03012345,  96, 32'h44332211, 32'h88776655};
        tbl[1] = '{1, 24'h012345, 16'd2, 32'h0B012345, 104, 32'h44332211, 32'h88776655};
        tbl[2] = '{0, 24'hABCDEF, 16'd1, 32'h03ABCDEF,  64, 32'h44332211, 32'h0};
        tbl[3] = '{1, 24'h000100, 16'd1, 32'h0B000100,  72, 32'h44332211, 32'h0};

        reset = 1'b1; start = '0; abort = '0; fifo_rd = '0; addr = '0; len = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state of both instances.
        for (int i = 0; i < 2; i++) begin
            chk("rst_css",   64'(css[i]),   64'd1);
            chk("rst_sck",   64'(sck[i]),   64'd0);
            chk("rst_mosi",  64'(mosi[i]),  64'd0);
            chk("rst_busy",  64'(busy[i]),  64'd0);
            chk("rst_done",  64'(done[i]),  64'd0);
            chk("rst_empty", 64'(empty[i]), 64'd1);
            chk("rst_level", 64'(level[i]), 64'd0);
            chk("rst_low",   64'(low[i]),   64'd1);
        end

        // Abort while the address phase presents bit 10.
        kick(0, 24'h0000AA, 16'd10);
        for (int c = 0; c < 500 && xr(0) < 18; c++) @(negedge clk);
        chk("abort_reach", 64'(xr(0)), 64'd18);
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        chk("abort_css",   64'(css[0]),   64'd1);
        chk("abort_sck",   64'(sck[0]),   64'd0);
        chk("abort_busy",  64'(busy[0]),  64'd0);
        chk("abort_empty", 64'(empty[0]), 64'd1);
        dones = 0;
        repeat (5) begin
            if (done[0]) dones++;
            @(negedge clk);
        end
        chk("abort_no_done", 64'(dones), 64'd0);
        $display("xfer abort-in-addr: inst 0 rises %0d", xr(0));

        // Start together with abort is ignored.
        f = nfalls(0);
        addr = 24'h000001; len = 16'd1; start[0] = 1'b1; abort[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0; abort[0] = 1'b0;
        chk("start_abort_busy", 64'(busy[0]), 64'd0);
        chk("start_abort_css",  64'(css[0]),  64'd1);
        @(negedge clk);
        chk("start_abort_falls", 64'(nfalls(0)), 64'(f));

        // Fill the fast-read instance, then abort while paused: FIFO flushed.
        kick(1, 24'h000000, 16'd10);
        for (int c = 0; c < 3000 && level[1] != 3'd4; c++) @(negedge clk);
        repeat (60) @(negedge clk);
        chk("full_level", 64'(level[1]), 64'd4);
        chk("full_low",   64'(low[1]),   64'd0);
        chk("pause_css",  64'(css[1]),   64'd0);
        chk("pause_sck",  64'(sck[1]),   64'd0);
        chk("pause_rises", 64'(xr(1)),   64'd168);
        abort[1] = 1'b1;
        @(negedge clk);
        abort[1] = 1'b0;
        chk("flush_empty", 64'(empty[1]), 64'd1);
        chk("flush_level", 64'(level[1]), 64'd0);
        chk("flush_css",   64'(css[1]),   64'd1);
        chk("flush_busy",  64'(busy[1]),  64'd0);
        $display("xfer abort-while-paused: inst 1 rises %0d", xr(1));

        // Table of complete transfers.
        for (int t = 0; t < 4; t++) begin
            kick(tbl[t].inst, tbl[t].a, tbl[t].l);
            chk("acc_busy", 64'(busy[tbl[t].inst]), 64'd1);
            chk("acc_css",  64'(css[tbl[t].inst]),  64'd0);
            wait_done(tbl[t].inst, dones, dcss, dbusy);
            chk("done_count", 64'(dones), 64'd1);
            chk("done_css",   64'(dcss),  64'd1);
            chk("done_busy",  64'(dbusy), 64'd0);
            chk("cmd_addr",   64'(mcap(tbl[t].inst)), 64'(tbl[t].cmd));
            chk("sck_rises",  64'(xr(tbl[t].inst)),   64'(tbl[t].rises));
            chk("xfer_level", 64'(level[tbl[t].inst]), 64'(tbl[t].l));
            for (int w = 0; w < int'(tbl[t].l); w++) begin
                ew = (w == 0) ? tbl[t].w0 : tbl[t].w1;
                chk("xfer_word", 64'(dout[tbl[t].inst]), 64'(ew));
                pop(tbl[t].inst);
            end
            chk("xfer_empty", 64'(empty[tbl[t].inst]), 64'd1);
            $display("xfer %0d: inst %0d addr %06h len %0d rises %0d cmd %08h",
                     t, tbl[t].inst, tbl[t].a, tbl[t].l, xr(tbl[t].inst), mcap(tbl[t].inst));
        end

        // Backpressure: 10 words into a 4-deep FIFO with no pops.
        kick(0, 24'h000000, 16'd10);
        for (int c = 0; c < 2000 && level[0] != 3'd4; c++) @(negedge clk);
        repeat (50) @(negedge clk);
        chk("bp_level", 64'(level[0]), 64'd4);
        chk("bp_css",   64'(css[0]),   64'd0);
        chk("bp_sck",   64'(sck[0]),   64'd0);
        chk("bp_busy",  64'(busy[0]),  64'd1);
        chk("bp_rises", 64'(xr(0)),    64'd160);
        chk("bp_head",  64'(dout[0]),  64'(exp_word(0)));
        pop(0);
        repeat (150) @(negedge clk);
        chk("bp_one_word", 64'(xr(0)),     64'd192);
        chk("bp_refill",   64'(level[0]),  64'd4);
        j = 1;
        dones = 0;
        for (int c = 0; c < 3000; c++) begin
            if (done[0]) dones++;
            if (j == 10 && !busy[0]) break;
            if (!empty[0] && j < 10) begin
                chk("bp_word", 64'(dout[0]), 64'(exp_word(j)));
                j++;
                fifo_rd[0] = 1'b1;
            end else begin
                fifo_rd[0] = 1'b0;
            end
            @(negedge clk);
        end
        fifo_rd[0] = 1'b0;
        @(negedge clk);
        chk("bp_popped", 64'(j),        64'd10);
        chk("bp_dones",  64'(dones),    64'd1);
        chk("bp_empty",  64'(empty[0]), 64'd1);
        chk("bp_total_rises", 64'(xr(0)), 64'd352);
        $display("xfer backpressure: inst 0 words %0d rises %0d", j, xr(0));

        // Zero length: done next cycle, CS untouched.
        f = nfalls(0);
        kick(0, 24'h123456, 16'd0);
        chk("len0_done", 64'(done[0]), 64'd1);
        chk("len0_busy", 64'(busy[0]), 64'd0);
        chk("len0_css",  64'(css[0]),  64'd1);
        @(negedge clk);
        chk("len0_done_once", 64'(done[0]), 64'd0);
        chk("len0_falls", 64'(nfalls(0)), 64'(f));
        $display("xfer len0: inst 0");

        // A second start while busy is ignored.
        kick(0, 24'h111111, 16'd1);
        repeat (5) @(negedge clk);
        kick(0, 24'h222222, 16'd5);
        wait_done(0, dones, dcss, dbusy);
        chk("busy_start_cmd",   64'(mcap(0)),   64'h03111111);
        chk("busy_start_level", 64'(level[0]),  64'd1);
        chk("busy_start_word",  64'(dout[0]),   64'(exp_word(0)));
        pop(0);
        chk("busy_start_empty", 64'(empty[0]),  64'd1);
        $display("xfer ignored-start: inst 0 cmd %08h", mcap(0));

        // Reset in the middle of the data phase.
        kick(0, 24'h000000, 16'd2);
        for (int c = 0; c < 500 && xr(0) < 40; c++) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_css",   64'(css[0]),   64'd1);
        chk("mid_rst_sck",   64'(sck[0]),   64'd0);
        chk("mid_rst_busy",  64'(busy[0]),  64'd0);
        chk("mid_rst_empty", 64'(empty[0]), 64'd1);
        chk("mid_rst_level", 64'(level[0]), 64'd0);
        r = rraw(0);
        repeat (50) @(negedge clk);
        chk("mid_rst_quiet", 64'(rraw(0)), 64'(r));
        $display("xfer reset-in-data: inst 0");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
